// File: rtl/phy_tx_arbiter.sv
// phy_tx_arbiter: shares the PHY transmit word slot among N_REQ requesters,
// round-robin with a per-grant burst limit, one word per WORD_PERIOD cycles.
module phy_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 32,
    parameter int WORD_PERIOD = 16,
    parameter int MAX_BURST   = 4
) (
    input  logic                     clk_32f,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*DATA_W-1:0]  data_req,
    output logic [N_REQ-1:0]         ack,
    output logic [DATA_W-1:0]        data_out,
    output logic                     valid_out,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     slot_start
);
    localparam int ID_W = $clog2(N_REQ);
    localparam int CW   = $clog2(WORD_PERIOD);
    localparam int BW   = $clog2(MAX_BURST + 1);

    logic [CW-1:0]     r_cnt;
    logic [BW-1:0]     r_burst;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_gid;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [N_REQ-1:0]  r_ack;
    logic              r_slot;

    logic              w_boundary;
    logic              w_cont;
    logic              w_found;
    logic              w_take;
    logic [ID_W-1:0]   w_idx;
    logic [ID_W-1:0]   w_sel;
    logic [ID_W-1:0]   w_next;

    assign w_boundary = r_cnt == CW'(WORD_PERIOD - 1);
    assign w_cont     = req[r_gid] && r_valid && (r_burst < BW'(MAX_BURST));
    assign w_next     = w_cont ? r_gid : w_sel;
    assign w_take     = w_cont || w_found;

    // r_ptr is one past the last new grant, so the current owner is searched last
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_gid;
        w_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = r_ptr + ID_W'(k);
            if (req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_burst <= '0;
            r_ptr   <= '0;
            r_gid   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ack   <= '0;
            r_slot  <= 1'b0;
        end else begin
            r_cnt  <= w_boundary ? '0 : r_cnt + CW'(1);
            r_slot <= w_boundary;
            r_ack  <= '0;
            if (w_boundary) begin
                r_valid <= w_take;
                r_data  <= w_take ? data_req[w_next*DATA_W +: DATA_W] : '0;
                r_ack   <= w_take ? N_REQ'(1) << w_next : '0;
                if (w_cont) begin
                    r_burst <= r_burst + BW'(1);
                end else if (w_found) begin
                    r_gid   <= w_sel;
                    r_burst <= BW'(1);
                    r_ptr   <= w_sel + ID_W'(1);
                end
            end
        end
    end

    assign ack        = r_ack;
    assign data_out   = r_data;
    assign valid_out  = r_valid;
    assign grant_id   = r_gid;
    assign slot_start = r_slot;
endmodule

// File: tb/tb_phy_tx_arbiter.sv
// tb_phy_tx_arbiter: directed scenarios with a queue-based scoreboard fed by a
// behavioural arbiter model evaluated at every slot boundary.
module tb_phy_tx_arbiter;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int WP = 16;
    localparam int MB = 4;

    typedef struct packed {
        logic [N-1:0] ack;
        logic         valid;
        logic [W-1:0] data;
        logic [1:0]   gid;
    } exp_t;

    logic           clk_32f = 1'b0;
    logic           reset   = 1'b1;
    logic [N-1:0]   req;
    logic [N*W-1:0] data_req;
    logic [N-1:0]   ack;
    logic [W-1:0]   data_out;
    logic           valid_out;
    logic [1:0]     grant_id;
    logic           slot_start;

    exp_t         q[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           left[N];
    logic [W-1:0] words[N];
    logic [1:0]   m_gid, m_ptr;
    int           m_burst;
    logic         m_valid;
    logic [W-1:0] m_data;
    logic [N-1:0] m_ack;

    phy_tx_arbiter #(.N_REQ(N), .DATA_W(W), .WORD_PERIOD(WP), .MAX_BURST(MB)) dut (
        .clk_32f(clk_32f), .reset(reset), .req(req), .data_req(data_req),
        .ack(ack), .data_out(data_out), .valid_out(valid_out),
        .grant_id(grant_id), .slot_start(slot_start)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] obs_vec();
        return {24'd0, slot_start, ack, valid_out, data_out, grant_id};
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i] = left[i] > 0;
            data_req[i*W +: W] = words[i];
        end
    endtask

    task automatic model_reset();
        m_gid = 0; m_ptr = 0; m_burst = 0; m_valid = 0; m_data = 0; m_ack = 0;
        q.delete();
    endtask

    // Arbitration as described: continue under the burst limit, else search from the pointer
    task automatic model_boundary();
        bit         found = 0;
        logic [1:0] j;
        m_ack = 0;
        if (req[m_gid] && m_valid && m_burst < MB) begin
            m_burst++;
            found = 1;
        end else begin
            for (int i = 0; i < N; i++) begin
                j = m_ptr + 2'(i);
                if (!found && req[j]) begin
                    found = 1; m_gid = j; m_burst = 1; m_ptr = j + 2'd1;
                end
            end
        end
        m_valid = found;
        m_data  = found ? words[m_gid] : '0;
        if (found) m_ack[m_gid] = 1'b1;
        q.push_back('{m_ack, m_valid, m_data, m_gid});
    endtask

    task automatic run_slot(input string tag);
        exp_t e;
        repeat (WP - 1) begin
            @(posedge clk_32f); #1;
            chk({tag, "/hold"}, obs_vec(), {24'd0, 1'b0, 4'b0, m_valid, m_data, m_gid});
        end
        model_boundary();
        @(posedge clk_32f); #1;
        e = q.pop_front();
        chk({tag, "/slot"}, obs_vec(), {24'd0, 1'b1, e.ack, e.valid, e.data, e.gid});
        for (int i = 0; i < N; i++) if (e.ack[i]) begin left[i]--; words[i]++; end
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("async_reset", obs_vec(), 64'd0);
        model_reset();
        repeat (3) @(negedge clk_32f);
        reset = 1'b1;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin left[i] = 0; words[i] = 0; end
        drive();
    endtask

    initial begin
        clear_all();
        #2;
        do_reset();
        for (int k = 0; k < 3; k++) run_slot("idle");

        do_reset();
        words[2] = 32'hA5A5_0001; left[2] = 6; drive();
        for (int k = 0; k < 6; k++) begin
            run_slot("single");
            chk("single_data", {31'd0, valid_out, data_out}, {31'd0, 1'b1, 32'hA5A5_0001 + 32'(k)});
            chk("single_gid", 64'(grant_id), 64'd2);
        end
        run_slot("single_end");

        do_reset();
        for (int i = 0; i < N; i++) begin left[i] = 1000; words[i] = 32'h1000_0000 * 32'(i + 1); end
        drive();
        for (int k = 0; k < 20; k++) begin
            run_slot("burst");
            chk("burst_seq", 64'(grant_id), 64'((k / 4) % 4));
        end
        clear_all();
        run_slot("burst_end");

        do_reset();
        left[0] = 1000; left[3] = 1000; words[0] = 32'h0000_0100; words[3] = 32'h0300_0000;
        drive();
        for (int k = 0; k < 10; k++) begin
            run_slot("skip");
            chk("skip_seq", 64'(grant_id), ((k / 4) % 2) != 0 ? 64'd3 : 64'd0);
        end
        clear_all();
        run_slot("skip_end");

        do_reset();
        left[1] = 2; words[1] = 32'h1111_0000; drive();
        run_slot("gap_a");
        run_slot("gap_b");
        run_slot("gap_idle");
        chk("gap_valid", {31'd0, valid_out, data_out}, 64'd0);
        left[0] = 1; left[1] = 1; left[2] = 1;
        words[0] = 32'h0000_00A0; words[2] = 32'h2222_0000; drive();
        run_slot("gap_resume");
        chk("gap_resume_gid", 64'(grant_id), 64'd2);
        run_slot("gap_next");
        chk("gap_next_gid", 64'(grant_id), 64'd0);
        run_slot("gap_last");
        chk("gap_last_gid", 64'(grant_id), 64'd1);
        run_slot("gap_end");

        do_reset();
        left[3] = 3; words[3] = 32'hDEAD_0001; drive();
        run_slot("rst_pre");
        repeat (7) @(posedge clk_32f);
        #1;
        chk("rst_mid_valid", {31'd0, valid_out, data_out}, {31'd0, 1'b1, 32'hDEAD_0001});
        do_reset();
        run_slot("rst_resend");
        chk("rst_resend_data", {28'd0, ack, data_out}, {28'd0, 4'b1000, 32'hDEAD_0002});
        run_slot("rst_next");
        run_slot("rst_end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
